motor_drive_ctrl: RTL

- Downstream consumer of the mode FSM's 3-bit drive_state. Converts it into two PWM/direction pairs (left and right motor) for the H-bridge pins.
- Duty is ramped, not stepped, so motors are not slammed.
- A direction reversal is enforced as ramp to zero, then dead-time, then flip direction.
- The estop input forces both motors off immediately.

---
 rtl/drive_pkg.sv | 25 ++
 rtl/motor_channel.sv | 108 ++++++++++
 rtl/motor_drive_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/drive_pkg.sv
// Shared types for the motor drive path: drive-state codes from the mode FSM
// and the per-motor channel state.
package drive_pkg;

  typedef enum logic [2:0] {
    DS_STOP   = 3'd0,
    DS_LEFT   = 3'd1,
    DS_RIGHT  = 3'd2,
    DS_SLOW   = 3'd3,
    DS_MEDIUM = 3'd4,
    DS_FAST   = 3'd5
  } drive_state_e;

  typedef enum logic {
    CH_RUN  = 1'b0,
    CH_DEAD = 1'b1
  } ch_state_e;

  // Limit a requested duty to a full PWM period (constant high).
  function automatic int unsigned clamp_duty(input int unsigned duty,
                                             input int unsigned period);
    return (duty > period) ? period : duty;
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One motor channel: duty ramp, direction reversal through dead-time,
// period-aligned compare latch and PWM comparator.
module motor_channel
  import drive_pkg::*;
#(
  parameter int unsigned DUTY_W       = 12,
  parameter int unsigned RAMP_STEP    = 25,
  parameter int unsigned DEADTIME_CYC = 50000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic              boundary_i,
  input  logic              estop_i,
  input  logic              tgt_dir_i,
  input  logic [DUTY_W-1:0] tgt_duty_i,
  input  logic [DUTY_W-1:0] pwm_cnt_i,
  output logic              dir_o,
  output logic              pwm_o,
  output logic [DUTY_W-1:0] duty_o
);

  localparam int unsigned DCW = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
  localparam logic [DCW-1:0]    DEAD_LAST = DCW'(DEADTIME_CYC - 1);
  localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(RAMP_STEP);

  ch_state_e         state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] cmp_q, cmp_d;
  logic              dir_q, dir_d;
  logic [DCW-1:0]    dead_cnt_q, dead_cnt_d;
  logic [DUTY_W-1:0] eff_tgt;
  logic [DUTY_W-1:0] ramp_next;

  // Saturating one-step move of the duty toward the effective target.
  always_comb begin
    eff_tgt   = (tgt_dir_i == dir_q) ? tgt_duty_i : '0;
    ramp_next = duty_q;
    if (duty_q < eff_tgt) begin
      ramp_next = ((eff_tgt - duty_q) > STEP) ? duty_q + STEP : eff_tgt;
    end else if (duty_q > eff_tgt) begin
      ramp_next = ((duty_q - eff_tgt) > STEP) ? duty_q - STEP : eff_tgt;
    end
  end

  // Channel FSM: ramp in RUN, hold zero and flip direction at end of DEAD.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    cmp_d      = cmp_q;
    dir_d      = dir_q;
    dead_cnt_d = dead_cnt_q;
    if (boundary_i) begin
      cmp_d = duty_q;
    end
    if (estop_i) begin
      state_d    = CH_DEAD;
      dead_cnt_d = '0;
      duty_d     = '0;
      cmp_d      = '0;
    end else begin
      case (state_q)
        CH_RUN: begin
          if (tick_i) begin
            duty_d = ramp_next;
          end
          if ((tgt_dir_i != dir_q) && (duty_q == '0) && boundary_i) begin
            state_d    = CH_DEAD;
            dead_cnt_d = '0;
          end
        end
        CH_DEAD: begin
          duty_d = '0;
          if (dead_cnt_q == DEAD_LAST) begin
            dir_d      = tgt_dir_i;
            state_d    = CH_RUN;
            dead_cnt_d = '0;
          end else begin
            dead_cnt_d = dead_cnt_q + 1'b1;
          end
        end
        default: state_d = CH_RUN;
      endcase
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= CH_RUN;
      duty_q     <= '0;
      cmp_q      <= '0;
      dir_q      <= 1'b1;
      dead_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      cmp_q      <= cmp_d;
      dir_q      <= dir_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

  assign pwm_o  = (pwm_cnt_i < cmp_q);
  assign duty_o = cmp_q;
  assign dir_o  = dir_q;

endmodule

// File: rtl/motor_drive_ctrl.sv
// Drive-state to dual H-bridge PWM/direction conversion with ramped duty,
// dead-time protected reversals and emergency stop.
module motor_drive_ctrl
  import drive_pkg::*;
#(
  parameter int unsigned PWM_PERIOD   = 2500,
  parameter int unsigned DUTY_W       = 12,
  parameter int unsigned RAMP_DIV     = 25000,
  parameter int unsigned RAMP_STEP    = 25,
  parameter int unsigned DEADTIME_CYC = 50000,
  parameter int unsigned DUTY_TURN    = 1250,
  parameter int unsigned DUTY_SLOW    = 1000,
  parameter int unsigned DUTY_MED     = 1625,
  parameter int unsigned DUTY_FAST    = 2250
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic [2:0]        drive_state,
  input  logic              mode_reset,
  input  logic              estop,
  output logic              pwm_l,
  output logic              pwm_r,
  output logic              dir_l,
  output logic              dir_r,
  output logic [DUTY_W-1:0] duty_l,
  output logic [DUTY_W-1:0] duty_r,
  output logic              moving
);

  localparam int unsigned PCW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PCW-1:0]    DIV_LAST    = PCW'(RAMP_DIV - 1);
  localparam logic [DUTY_W-1:0] PERIOD_LAST = DUTY_W'(PWM_PERIOD - 1);
  localparam logic [DUTY_W-1:0] V_TURN = DUTY_W'(clamp_duty(DUTY_TURN, PWM_PERIOD));
  localparam logic [DUTY_W-1:0] V_SLOW = DUTY_W'(clamp_duty(DUTY_SLOW, PWM_PERIOD));
  localparam logic [DUTY_W-1:0] V_MED  = DUTY_W'(clamp_duty(DUTY_MED, PWM_PERIOD));
  localparam logic [DUTY_W-1:0] V_FAST = DUTY_W'(clamp_duty(DUTY_FAST, PWM_PERIOD));

  logic [2:0]        drive_state_q;
  logic [PCW-1:0]    presc_q, presc_d;
  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic              tick, boundary;
  logic              tgt_dir_l, tgt_dir_r;
  logic [DUTY_W-1:0] tgt_duty_l, tgt_duty_r;
  logic              pwm_l_raw, pwm_r_raw;

  // Map the registered drive state to per-motor direction and duty targets.
  always_comb begin
    tgt_dir_l  = dir_l;
    tgt_dir_r  = dir_r;
    tgt_duty_l = '0;
    tgt_duty_r = '0;
    case (drive_state_q)
      DS_LEFT: begin
        tgt_dir_l  = 1'b0;
        tgt_dir_r  = 1'b1;
        tgt_duty_l = V_TURN;
        tgt_duty_r = V_TURN;
      end
      DS_RIGHT: begin
        tgt_dir_l  = 1'b1;
        tgt_dir_r  = 1'b0;
        tgt_duty_l = V_TURN;
        tgt_duty_r = V_TURN;
      end
      DS_SLOW: begin
        tgt_dir_l  = 1'b1;
        tgt_dir_r  = 1'b1;
        tgt_duty_l = V_SLOW;
        tgt_duty_r = V_SLOW;
      end
      DS_MEDIUM: begin
        tgt_dir_l  = 1'b1;
        tgt_dir_r  = 1'b1;
        tgt_duty_l = V_MED;
        tgt_duty_r = V_MED;
      end
      DS_FAST: begin
        tgt_dir_l  = 1'b1;
        tgt_dir_r  = 1'b1;
        tgt_duty_l = V_FAST;
        tgt_duty_r = V_FAST;
      end
      default: ;
    endcase
  end

  // Ramp prescaler and PWM period counter next-state.
  always_comb begin
    tick     = (presc_q == DIV_LAST) && !mode_reset;
    boundary = (pwm_cnt_q == '0);
    if (mode_reset || (presc_q == DIV_LAST)) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
    pwm_cnt_d = (pwm_cnt_q == PERIOD_LAST) ? '0 : pwm_cnt_q + 1'b1;
  end

  // Input register and shared counters.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      drive_state_q <= '0;
      presc_q       <= '0;
      pwm_cnt_q     <= '0;
    end else begin
      drive_state_q <= drive_state;
      presc_q       <= presc_d;
      pwm_cnt_q     <= pwm_cnt_d;
    end
  end

  motor_channel #(
    .DUTY_W       (DUTY_W),
    .RAMP_STEP    (RAMP_STEP),
    .DEADTIME_CYC (DEADTIME_CYC)
  ) u_chan_l (
    .clk_i      (clk_50),
    .rst_ni     (rst_n),
    .tick_i     (tick),
    .boundary_i (boundary),
    .estop_i    (estop),
    .tgt_dir_i  (tgt_dir_l),
    .tgt_duty_i (tgt_duty_l),
    .pwm_cnt_i  (pwm_cnt_q),
    .dir_o      (dir_l),
    .pwm_o      (pwm_l_raw),
    .duty_o     (duty_l)
  );

  motor_channel #(
    .DUTY_W       (DUTY_W),
    .RAMP_STEP    (RAMP_STEP),
    .DEADTIME_CYC (DEADTIME_CYC)
  ) u_chan_r (
    .clk_i      (clk_50),
    .rst_ni     (rst_n),
    .tick_i     (tick),
    .boundary_i (boundary),
    .estop_i    (estop),
    .tgt_dir_i  (tgt_dir_r),
    .tgt_duty_i (tgt_duty_r),
    .pwm_cnt_i  (pwm_cnt_q),
    .dir_o      (dir_r),
    .pwm_o      (pwm_r_raw),
    .duty_o     (duty_r)
  );

  // estop gates the bridge pins combinationally, ahead of the registered clear.
  assign pwm_l  = pwm_l_raw & ~estop;
  assign pwm_r  = pwm_r_raw & ~estop;
  assign moving = (|duty_l) | (|duty_r);

endmodule
